// File: rtl/score_overlay.sv
// Score overlay: converts a binary score to BCD in the background and draws
// it as seven-segment style digits over the video stream.
module score_overlay #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned SCORE_W      = 16,
    parameter int unsigned X0           = 50,
    parameter int unsigned Y0           = 139,
    parameter int unsigned PITCH        = 25,
    parameter int unsigned FLASH_FRAMES = 8,
    parameter int unsigned BLANK_LZ     = 0,
    parameter logic [11:0] FG           = 12'hFFF,
    parameter logic [11:0] BG           = 12'h000,
    parameter logic [11:0] FLASH_COLOUR = 12'h0FF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               frame_tick,
    output logic [11:0]        colour,
    output logic               in_overlay,
    output logic               busy,
    output logic               overflow
);

    localparam int unsigned NIB    = (SCORE_W + 2) / 3;
    localparam int unsigned BCD_W  = NIB * 4;
    localparam int unsigned PAD_N  = (NIB > DIGITS) ? NIB : DIGITS;
    localparam int unsigned PAD_W  = PAD_N * 4;
    localparam int unsigned DISP_W = DIGITS * 4;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned DIG_W  = 3;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] lat_q, lat_d, bin_q, bin_d, cmt_q, cmt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DISP_W-1:0]  disp_q, disp_d, bcd_low;
    logic [PAD_W-1:0]   bcd_pad;
    logic               hi_nz;
    logic               ovf_q, ovf_d, busy_q, busy_d;
    logic [7:0]         flash_q, flash_d;

    logic               hit_q, hit_d, in_y;
    logic [DIG_W-1:0]   dig_q, dig_d;
    logic [1:0]         col_q, col_d;
    logic [2:0]         row_q, row_d;
    logic [9:0]         dx, dy;
    logic [3:0]         cur_dig;
    logic               blank, zrun, lit;
    logic [2:0]         gbits;
    logic [11:0]        colour_q, colour_d;
    logic               in_ov_q, in_ov_d;

    // Glyph row lookup; bit 2 is the left column.
    function automatic logic [2:0] glyph(input logic [3:0] dig, input logic [2:0] row);
        logic [14:0] g;
        case (dig)
            4'd0:    g = {3'd7, 3'd5, 3'd5, 3'd5, 3'd7};
            4'd1:    g = {3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
            4'd2:    g = {3'd7, 3'd1, 3'd7, 3'd4, 3'd7};
            4'd3:    g = {3'd7, 3'd1, 3'd7, 3'd1, 3'd7};
            4'd4:    g = {3'd5, 3'd5, 3'd7, 3'd1, 3'd1};
            4'd5:    g = {3'd7, 3'd4, 3'd7, 3'd1, 3'd7};
            4'd6:    g = {3'd7, 3'd4, 3'd7, 3'd5, 3'd7};
            4'd7:    g = {3'd7, 3'd1, 3'd1, 3'd1, 3'd1};
            4'd8:    g = {3'd7, 3'd5, 3'd7, 3'd5, 3'd7};
            4'd9:    g = {3'd7, 3'd5, 3'd7, 3'd1, 3'd7};
            default: g = 15'd0;
        endcase
        case (row)
            3'd0:    glyph = g[14:12];
            3'd1:    glyph = g[11:9];
            3'd2:    glyph = g[8:6];
            3'd3:    glyph = g[5:3];
            default: glyph = g[2:0];
        endcase
    endfunction

    // Double-dabble correction: add 3 to every nibble of 5 or more.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(NIB); i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    // Split the finished BCD into displayed digits and an out-of-range flag.
    always_comb begin
        bcd_pad = PAD_W'(bcd_q);
        hi_nz   = 1'b0;
        for (int i = int'(DIGITS); i < int'(PAD_N); i++) begin
            hi_nz = hi_nz | (bcd_pad[i*4 +: 4] != 4'd0);
        end
        bcd_low = bcd_pad[DISP_W-1:0];
    end

    // Conversion FSM, commit and flash counter.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        cmt_d   = cmt_q;
        flash_d = flash_q;
        if (frame_tick && (flash_q != 8'd0)) flash_d = flash_q - 8'd1;
        case (state_q)
            IDLE: begin
                if (score != lat_q) begin
                    lat_d   = score;
                    bin_d   = score;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
                bin_d = {bin_q[SCORE_W-2:0], 1'b0};
                if (cnt_q == CNT_W'(SCORE_W - 1)) state_d = DONE;
                else                              cnt_d   = cnt_q + CNT_W'(1);
            end
            DONE: begin
                if (hi_nz) begin
                    disp_d = {DIGITS{4'd9}};
                    ovf_d  = 1'b1;
                end else begin
                    disp_d = bcd_low;
                    ovf_d  = 1'b0;
                end
                // A load beats a simultaneous frame tick.
                if (lat_q > cmt_q) flash_d = 8'(FLASH_FRAMES);
                cmt_d   = lat_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Stage 1: locate the pixel within a digit box.
    always_comb begin
        hit_d = 1'b0;
        dig_d = '0;
        dx    = '0;
        dy    = y - 10'(Y0);
        in_y  = (32'(y) >= Y0) && (32'(y) <= Y0 + 34);
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (in_y && (32'(x) >= X0 + d * PITCH) && (32'(x) <= X0 + d * PITCH + 19)) begin
                hit_d = 1'b1;
                dig_d = DIG_W'(d);
                dx    = x - 10'(X0 + d * PITCH);
            end
        end
        col_d = (dx < 10'd5) ? 2'd0 : (dx < 10'd15) ? 2'd1 : 2'd2;
        row_d = (dy < 10'd5)  ? 3'd0 : (dy < 10'd15) ? 3'd1 :
                (dy < 10'd20) ? 3'd2 : (dy < 10'd30) ? 3'd3 : 3'd4;
    end

    // Stage 2: glyph lookup, leading-zero blanking and colour select.
    always_comb begin
        cur_dig = '0;
        blank   = 1'b0;
        zrun    = 1'b1;
        for (int d = 0; d < int'(DIGITS); d++) begin
            zrun = zrun & (disp_q[(int'(DIGITS) - 1 - d)*4 +: 4] == 4'd0);
            if (dig_q == DIG_W'(d)) begin
                cur_dig = disp_q[(int'(DIGITS) - 1 - d)*4 +: 4];
                blank   = (BLANK_LZ != 0) && (d != int'(DIGITS) - 1) && zrun;
            end
        end
        gbits = glyph(cur_dig, row_q);
        case (col_q)
            2'd0:    lit = gbits[2];
            2'd1:    lit = gbits[1];
            default: lit = gbits[0];
        endcase
        lit      = lit && hit_q && !blank;
        colour_d = !lit ? BG : (flash_q != 8'd0) ? FLASH_COLOUR : FG;
        in_ov_d  = hit_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            bin_q    <= '0;
            cmt_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            disp_q   <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            flash_q  <= 8'd0;
            hit_q    <= 1'b0;
            dig_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            colour_q <= 12'h000;
            in_ov_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            bin_q    <= bin_d;
            cmt_q    <= cmt_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            disp_q   <= disp_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            flash_q  <= flash_d;
            hit_q    <= hit_d;
            dig_q    <= dig_d;
            col_q    <= col_d;
            row_q    <= row_d;
            colour_q <= colour_d;
            in_ov_q  <= in_ov_d;
        end
    end

    assign colour     = colour_q;
    assign in_overlay = in_ov_q;
    assign busy       = busy_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_score_overlay.sv
// Directed bench for score_overlay: default instance plus a leading-zero-blanking instance.
module tb_score_overlay;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] score;
    logic [9:0]  x, y;
    logic        frame_tick;
    logic [11:0] colour, b_colour;
    logic        in_overlay, busy, overflow;
    logic        b_in_overlay, b_busy, b_overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    score_overlay u_dut (
        .clk(clk), .reset(reset), .score(score), .x(x), .y(y), .frame_tick(frame_tick),
        .colour(colour), .in_overlay(in_overlay), .busy(busy), .overflow(overflow)
    );

    score_overlay #(.BLANK_LZ(1)) u_blz (
        .clk(clk), .reset(reset), .score(score), .x(x), .y(y), .frame_tick(frame_tick),
        .colour(b_colour), .in_overlay(b_in_overlay), .busy(b_busy), .overflow(b_overflow)
    );

    typedef struct {
        logic [9:0]  px;
        logic [9:0]  py;
        logic [11:0] col;
        logic        inov;
    } vec_t;

    vec_t tab [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a pixel and sample both instances two cycles later.
    task automatic pix(input logic [9:0] px, input logic [9:0] py,
                       output logic [11:0] c, output logic o,
                       output logic [11:0] bc, output logic bo);
        @(negedge clk);
        x = px;
        y = py;
        @(posedge clk);
        @(posedge clk);
        #1;
        c  = colour;
        o  = in_overlay;
        bc = b_colour;
        bo = b_in_overlay;
    endtask

    // Change the score and wait for the conversion to finish; returns busy cycles.
    task automatic convert(input logic [15:0] v, output int cyc);
        logic seen = 1'b0;
        logic done = 1'b0;
        @(negedge clk);
        score = v;
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) begin
                cyc++;
                seen = 1'b1;
            end else if (seen) begin
                done = 1'b1;
                break;
            end
        end
        chk("conversion_completes", 32'(done), 32'd1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] c, bc;
        logic        o, bo;
        int          cyc;

        // Pixel checks for display 1234 with no highlight active.
        tab[0]  = '{10'd50,  10'd139, 12'h000, 1'b1};
        tab[1]  = '{10'd65,  10'd139, 12'hFFF, 1'b1};
        tab[2]  = '{10'd75,  10'd139, 12'hFFF, 1'b1};
        tab[3]  = '{10'd75,  10'd159, 12'hFFF, 1'b1};
        tab[4]  = '{10'd90,  10'd159, 12'h000, 1'b1};
        tab[5]  = '{10'd105, 10'd154, 12'hFFF, 1'b1};
        tab[6]  = '{10'd100, 10'd149, 12'h000, 1'b1};
        tab[7]  = '{10'd125, 10'd144, 12'hFFF, 1'b1};
        tab[8]  = '{10'd130, 10'd154, 12'hFFF, 1'b1};
        tab[9]  = '{10'd130, 10'd139, 12'h000, 1'b1};
        tab[10] = '{10'd144, 10'd173, 12'hFFF, 1'b1};
        tab[11] = '{10'd145, 10'd173, 12'h000, 1'b0};
        tab[12] = '{10'd144, 10'd174, 12'h000, 1'b0};
        tab[13] = '{10'd70,  10'd150, 12'h000, 1'b0};
        tab[14] = '{10'd50,  10'd138, 12'h000, 1'b0};

        reset = 1'b1;
        score = 16'd0;
        x = 10'd0;
        y = 10'd0;
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_colour", 32'(colour), 32'h000);
        chk("reset_in_overlay", 32'(in_overlay), 32'd0);
        reset = 1'b0;

        // Display 0000 after reset.
        pix(10'd50, 10'd139, c, o, bc, bo);
        chk("r_zero_colour", 32'(c), 32'hFFF);
        chk("r_zero_inov", 32'(o), 32'd1);
        pix(10'd55, 10'd144, c, o, bc, bo);
        chk("r_hole_colour", 32'(c), 32'h000);
        chk("r_hole_inov", 32'(o), 32'd1);
        pix(10'd45, 10'd139, c, o, bc, bo);
        chk("r_left_inov", 32'(o), 32'd0);
        chk("idle_no_busy", 32'(busy), 32'd0);

        // 0 -> 1234: busy length, highlight, then table scan.
        convert(16'd1234, cyc);
        chk("busy_cycles", 32'(cyc), 32'd17);
        chk("ovf_1234", 32'(overflow), 32'd0);
        pix(10'd65, 10'd139, c, o, bc, bo);
        chk("flash_1234", 32'(c), 32'h0FF);
        ticks(8);
        for (int i = 0; i < 15; i++) begin
            pix(tab[i].px, tab[i].py, c, o, bc, bo);
            chk($sformatf("tab%0d_colour", i), 32'(c), 32'(tab[i].col));
            chk($sformatf("tab%0d_inov", i), 32'(o), 32'(tab[i].inov));
        end

        // Overflow saturates to 9999, then recovers.
        convert(16'd12345, cyc);
        chk("ovf_set", 32'(overflow), 32'd1);
        pix(10'd65, 10'd164, c, o, bc, bo);
        chk("nines_c2r3_flash", 32'(c), 32'h0FF);
        pix(10'd50, 10'd164, c, o, bc, bo);
        chk("nines_c0r3", 32'(c), 32'h000);
        ticks(8);
        convert(16'd42, cyc);
        chk("ovf_clear", 32'(overflow), 32'd0);
        pix(10'd50, 10'd139, c, o, bc, bo);
        chk("d0_zero", 32'(c), 32'hFFF);
        chk("blz_d0_blank", 32'(bc), 32'h000);
        chk("blz_d0_inov", 32'(bo), 32'd1);
        pix(10'd100, 10'd159, c, o, bc, bo);
        chk("d2_four_c0r3", 32'(c), 32'h000);
        pix(10'd115, 10'd159, c, o, bc, bo);
        chk("d2_four_c2r3", 32'(c), 32'hFFF);
        chk("blz_d2_four", 32'(bc), 32'hFFF);
        pix(10'd125, 10'd139, c, o, bc, bo);
        chk("d3_two_r0", 32'(c), 32'hFFF);

        // Highlight only on increase, for exactly FLASH_FRAMES ticks.
        convert(16'd5, cyc);
        pix(10'd125, 10'd139, c, o, bc, bo);
        chk("decrease_no_flash", 32'(c), 32'hFFF);
        convert(16'd6, cyc);
        pix(10'd125, 10'd139, c, o, bc, bo);
        chk("increase_flash", 32'(c), 32'h0FF);
        ticks(7);
        pix(10'd125, 10'd139, c, o, bc, bo);
        chk("flash_after7", 32'(c), 32'h0FF);
        ticks(1);
        pix(10'd125, 10'd139, c, o, bc, bo);
        chk("flash_after8", 32'(c), 32'hFFF);
        convert(16'd5, cyc);
        pix(10'd125, 10'd139, c, o, bc, bo);
        chk("down_no_flash", 32'(c), 32'hFFF);

        // Leading-zero blanking.
        convert(16'd7, cyc);
        ticks(8);
        pix(10'd50, 10'd139, c, o, bc, bo);
        chk("blz7_d0", 32'(bc), 32'h000);
        chk("noblz7_d0", 32'(c), 32'hFFF);
        pix(10'd75, 10'd139, c, o, bc, bo);
        chk("blz7_d1", 32'(bc), 32'h000);
        pix(10'd100, 10'd139, c, o, bc, bo);
        chk("blz7_d2", 32'(bc), 32'h000);
        pix(10'd125, 10'd139, c, o, bc, bo);
        chk("blz7_d3", 32'(bc), 32'hFFF);
        convert(16'd0, cyc);
        pix(10'd125, 10'd164, c, o, bc, bo);
        chk("blz0_d3", 32'(bc), 32'hFFF);
        pix(10'd50, 10'd164, c, o, bc, bo);
        chk("blz0_d0", 32'(bc), 32'h000);
        chk("noblz0_d0", 32'(c), 32'hFFF);

        // Reset during conversion aborts it; conversion restarts after release.
        @(negedge clk);
        score = 16'd99;
        repeat (5) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        x = 10'd125;
        y = 10'd164;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("abort_display_zero", 32'(colour), 32'hFFF);
        repeat (15) @(posedge clk);
        #1;
        chk("restart_busy_e17", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("restart_idle_e18", 32'(busy), 32'd0);
        pix(10'd125, 10'd164, c, o, bc, bo);
        chk("ninetynine_c0r3", 32'(c), 32'h000);
        pix(10'd140, 10'd164, c, o, bc, bo);
        chk("ninetynine_c2r3", 32'(c), 32'h0FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_overlay.md
SCORE_OVERLAY -- requirements
Module: score_overlay

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of displayed decimal digits, 1..8.
REQ-002 SHALL have parameter SCORE_W, default 16: binary score width, 4..24.
REQ-003 SHALL have parameter X0, default 50: left pixel column of digit 0, the most significant digit.
REQ-004 SHALL have parameter Y0, default 139: top pixel row of all digits.
REQ-005 SHALL have parameter PITCH, default 25: horizontal distance between digit origins, at least 20.
REQ-006 SHALL have parameter FLASH_FRAMES, default 8: length of the score-increase highlight, in frames, 1..255.
REQ-007 SHALL have parameter BLANK_LZ, default 0: 1 blanks leading zeros.
REQ-008 SHALL have parameters FG, BG and FLASH_COLOUR, defaults 12'hFFF, 12'h000 and 12'h0FF: lit, unlit and highlight colours.
REQ-009 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-010 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-011 SHALL have port score, input, SCORE_W bits: binary score, which may change at any cycle.
REQ-012 SHALL have ports x and y, input, 10 bits each: current pixel coordinates.
REQ-013 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per video frame.
REQ-014 SHALL have port colour, output, 12 bits: pixel colour, valid 2 cycles after x/y.
REQ-015 SHALL have port in_overlay, output, 1 bit: high when the pixel 2 cycles earlier was inside a digit box.
REQ-016 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-017 SHALL have port overflow, output, 1 bit: high when the last committed score exceeded 10^DIGITS-1.

Function
REQ-018 Conversion FSM SHALL have states IDLE, SHIFT and DONE.
REQ-019 In IDLE, if score differs from the latched score, the FSM SHALL latch score and move to SHIFT.
REQ-020 SHIFT SHALL run exactly SCORE_W double-dabble iterations, one per cycle: add 3 to every BCD nibble >=5, then shift left 1.
REQ-021 The internal BCD SHALL be ceil(SCORE_W/3) nibbles wide.
REQ-022 After the last SHIFT cycle the FSM SHALL go to DONE; in DONE it SHALL commit the low DIGITS nibbles to the display register and return to IDLE.
REQ-023 If any nibble above DIGITS-1 is nonzero, DONE SHALL commit all 9s and set overflow; otherwise it SHALL clear overflow.
REQ-024 busy SHALL be high in SHIFT and DONE, i.e. SCORE_W+1 cycles; the new digits SHALL be visible from the next cycle.
REQ-025 Score changes while busy SHALL be ignored until IDLE, then detected against the latched value; the final value SHALL always be displayed.
REQ-026 At commit, if the latched score exceeds the previously committed score, the flash counter SHALL load FLASH_FRAMES; a decrease or equal value SHALL leave it unchanged.
REQ-027 The flash counter SHALL decrement on frame_tick when nonzero; a load SHALL win over a simultaneous frame_tick.
REQ-028 Digit d (0..DIGITS-1) SHALL occupy box x in [X0+d*PITCH, +19] and y in [Y0, +34].
REQ-029 Box columns SHALL be c0=0-4, c1=5-14 and c2=15-19 px.
REQ-030 Box rows SHALL be r0=0-4, r1=5-14, r2=15-19, r3=20-29 and r4=30-34 px.
REQ-031 Glyph rows r0..r4 SHALL be 3-bit values, bit2=c0: 0=7,5,5,5,7; 1=1,1,1,1,1; 2=7,1,7,4,7; 3=7,1,7,1,7; 4=5,5,7,1,1; 5=7,4,7,1,7; 6=7,4,7,5,7; 7=7,1,1,1,1; 8=7,5,7,5,7; 9=7,5,7,1,7.
REQ-032 Pipeline stage 1 SHALL register hit, digit index, column and row; stage 2 SHALL register colour and in_overlay.
REQ-033 colour SHALL be FLASH_COLOUR if lit and the flash counter is nonzero, FG if lit, and BG otherwise, including outside all boxes.
REQ-034 With BLANK_LZ=1, zero digits above the most significant nonzero digit SHALL be unlit; digit DIGITS-1 SHALL always be drawn.
REQ-035 Geometry SHALL use 10-bit unsigned compares; boxes reaching past x=1023 SHALL NOT wrap.

Reset
REQ-036 On reset, colour, in_overlay, busy, overflow, the display digits, the latched score and the flash counter SHALL all be 0, and the FSM SHALL be in IDLE.
REQ-037 Reset mid-conversion SHALL abort the conversion with no commit; a nonzero score SHALL restart conversion in the first cycle after reset.

Verification
REQ-038 Reset, score=0, x,y=(50,139) -> colour=FFF, in_overlay=1 two cycles later; (55,144) -> 000, in_overlay=1; (45,139) -> in_overlay=0.
REQ-039 score 0->1234 -> busy high exactly 17 cycles, then digits read 1,2,3,4 by pixel scan, overflow=0.
REQ-040 score=12345 with DIGITS=4 -> display 9999, overflow=1; then score=42 -> 0042, overflow=0.
REQ-041 score 5->6, FLASH_FRAMES=8 -> lit pixels 0FF for 8 frame_ticks, then FFF; 6->5 -> no flash.
REQ-042 BLANK_LZ=1: score=7 -> digits 0-2 fully BG, digit 3 shows 7; score=0 -> only digit 3 shows 0.
REQ-043 Reset asserted mid-SHIFT with score=99 -> next cycle busy=0 and display 0000; after release, 99 is committed SCORE_W+2 cycles later.
